// File: rtl/alu_nibble_seq.sv
// Nibble-serial controller around a 4-bit combinational ALU: WIDTH-bit ops in, one nibble per cycle, assembled result out.
// Optional signed-overflow output out_ovf is enabled by defining ALU_NIBBLE_SEQ_OVF_EN.
module alu_nibble_seq #(
  parameter int  WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  output logic             alu_pass_a,
  output logic             alu_pass_b,
  output logic [1:0]       alu_opcode,
  input  logic [3:0]       alu_out,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_PARITY = 3'b011;
  localparam logic [2:0] OP_PASS_A = 3'b100;
  localparam logic [2:0] OP_PASS_B = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_cout_q, out_cout_d;
  logic             out_zero_q, out_zero_d;
  logic             out_err_q, out_err_d;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic             out_ovf_q, out_ovf_d;
`endif

  logic [IDXW+1:0]  sh_s;
  logic [WIDTH-1:0] a_sh_s, b_sh_s;
  logic [3:0]       nib_s;
  logic [WIDTH-1:0] final_res_s;

  assign sh_s   = {idx_q, 2'b00};
  assign a_sh_s = a_q >> sh_s;
  assign b_sh_s = b_q >> sh_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= {IDXW{1'b0}};
      carry_q      <= 1'b0;
      parity_q     <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      op_q         <= 3'b000;
      res_q        <= {WIDTH{1'b0}};
      out_result_q <= {WIDTH{1'b0}};
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      out_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      parity_q     <= parity_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      out_ovf_q    <= out_ovf_d;
`endif
    end
  end

  // Next-state, nibble accumulation and final result formatting
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    parity_d     = parity_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_err_d    = out_err_q;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    out_ovf_d    = out_ovf_q;
`endif
    nib_s        = 4'h0;
    final_res_s  = {WIDTH{1'b0}};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          op_d     = in_op;
          idx_d    = {IDXW{1'b0}};
          carry_d  = (in_op == OP_SUB);
          parity_d = 1'b0;
          res_d    = {WIDTH{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        // Parity contributes only via the running parity bit, never the nibble
        nib_s   = (op_q == OP_PARITY) ? 4'h0 : alu_out;
        res_d   = (res_q & ~(WIDTH'(4'hF) << sh_s)) | (WIDTH'(nib_s) << sh_s);
        carry_d = alu_cout;
        if (op_q == OP_PARITY) begin
          parity_d = parity_q ^ alu_out[0];
        end else begin
          parity_d = parity_q;
        end

        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          case (op_q)
            OP_AND, OP_ADD, OP_SUB, OP_PASS_A, OP_PASS_B: final_res_s = res_d;
            OP_PARITY: final_res_s = WIDTH'(parity_d);
            default:   final_res_s = {WIDTH{1'b0}};
          endcase
          out_result_d = final_res_s;
          out_zero_d   = is_zero(final_res_s);
          out_err_d    = (op_q[2:1] == 2'b11);
          case (op_q)
            OP_ADD:  out_cout_d = alu_cout;
            OP_SUB:  out_cout_d = ~alu_cout;
            default: out_cout_d = 1'b0;
          endcase
`ifdef ALU_NIBBLE_SEQ_OVF_EN
          case (op_q)
            OP_ADD:  out_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (final_res_s[WIDTH-1] != a_q[WIDTH-1]);
            OP_SUB:  out_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (final_res_s[WIDTH-1] != a_q[WIDTH-1]);
            default: out_ovf_d = 1'b0;
          endcase
`endif
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ALU drive for the current nibble; idle outside RUN
  always_comb begin
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_cin    = 1'b0;
    alu_pass_a = 1'b0;
    alu_pass_b = 1'b0;
    alu_opcode = 2'b00;
    if (state_q == RUN) begin
      case (op_q)
        OP_AND: begin
          alu_a = a_sh_s[3:0];
          alu_b = b_sh_s[3:0];
        end
        OP_ADD: begin
          alu_a      = a_sh_s[3:0];
          alu_b      = b_sh_s[3:0];
          alu_cin    = carry_q;
          alu_opcode = 2'b01;
        end
        // Subtract as A + ~B + 1 so the carry chains across nibbles
        OP_SUB: begin
          alu_a      = a_sh_s[3:0];
          alu_b      = ~b_sh_s[3:0];
          alu_cin    = carry_q;
          alu_opcode = 2'b01;
        end
        OP_PARITY: begin
          alu_a      = a_sh_s[3:0];
          alu_b      = b_sh_s[3:0];
          alu_opcode = 2'b11;
        end
        OP_PASS_A: begin
          alu_a      = a_sh_s[3:0];
          alu_b      = b_sh_s[3:0];
          alu_pass_a = 1'b1;
        end
        OP_PASS_B: begin
          alu_a      = a_sh_s[3:0];
          alu_b      = b_sh_s[3:0];
          alu_pass_b = 1'b1;
        end
        default: begin
          alu_a = 4'h0;
        end
      endcase
    end else begin
      alu_a = 4'h0;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  assign out_ovf    = out_ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq with a behavioural 4-bit ALU in the loop.
module tb_alu_nibble_seq;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic [3:0]       alu_a, alu_b, alu_out;
  logic             alu_cin, alu_pass_a, alu_pass_b, alu_cout;
  logic [1:0]       alu_opcode;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout, out_zero, out_err;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic             out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        err;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_pass_a (alu_pass_a),
    .alu_pass_b (alu_pass_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero),
    .out_err    (out_err)
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  // Behavioural 4-bit ALU
  always_comb begin
    alu_out  = 4'h0;
    alu_cout = 1'b0;
    if (alu_pass_a) begin
      alu_out = alu_a;
    end else if (alu_pass_b) begin
      alu_out = alu_b;
    end else begin
      case (alu_opcode)
        2'b00:   alu_out = alu_a & alu_b;
        2'b01:   {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
        2'b10:   alu_out = alu_a - alu_b;
        default: alu_out = {3'b000, ^alu_b};
      endcase
    end
  end

  wire [12:0] drive_s = {alu_a, alu_b, alu_cin, alu_pass_a, alu_pass_b, alu_opcode};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    exp_t e;
    logic [16:0] s;
    e = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[15:0];
        e.cout = s[16];
        e.ovf  = (a[15] == b[15]) && (e.res[15] != a[15]);
      end
      3'd2: begin
        e.res  = a - b;
        e.cout = (a < b);
        e.ovf  = (a[15] != b[15]) && (e.res[15] != a[15]);
      end
      3'd3:    e.res = {15'b0, ^b};
      3'd4:    e.res = a;
      3'd5:    e.res = b;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 16'h0000);
    return e;
  endfunction

  function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b, input logic c0, input int i);
    logic [31:0] m, sum;
    if (i == 0) return c0;
    m   = (32'd1 << (4 * i)) - 32'd1;
    sum = ({16'h0, a} & m) + ({16'h0, b} & m) + {31'b0, c0};
    return sum[4 * i];
  endfunction

  function automatic logic [12:0] exp_drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int i);
    logic [15:0] ash, bsh;
    logic [3:0]  an, bn;
    ash = a >> (4 * i);
    bsh = b >> (4 * i);
    an  = ash[3:0];
    bn  = bsh[3:0];
    case (op)
      3'd0:    return {an, bn, 1'b0, 1'b0, 1'b0, 2'b00};
      3'd1:    return {an, bn, carry_into(a, b, 1'b0, i), 1'b0, 1'b0, 2'b01};
      3'd2:    return {an, ~bn, carry_into(a, ~b, 1'b1, i), 1'b0, 1'b0, 2'b01};
      3'd3:    return {an, bn, 1'b0, 1'b0, 1'b0, 2'b11};
      3'd4:    return {an, bn, 1'b0, 1'b1, 1'b0, 2'b00};
      3'd5:    return {an, bn, 1'b0, 1'b0, 1'b1, 2'b00};
      default: return 13'h0;
    endcase
  endfunction

  // Issue one request from a negedge, follow it through RUN and DONE, retire it from the scoreboard
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input int hold, input bit valid_in_done);
    exp_t e;
    int   k, lat;
    bit   seen;
    sb_q.push_back(model(a, b, op));
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= NIB + 8 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = n - 1;
      end else if (n <= NIB) begin
        check_eq($sformatf("drive_op%0d_nib%0d", op, n - 1), 32'(drive_s), 32'(exp_drive(a, b, op, n - 1)));
      end else begin
        lat = n;
      end
    end
    if (!seen) begin
      check_eq("out_valid_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    check_eq("latency", 32'(lat), 32'(NIB));
    check_eq("drive_in_done", 32'(drive_s), 32'd0);
    if (valid_in_done) begin
      in_valid = 1'b1;
      in_a     = ~a;
      in_b     = ~b;
      in_op    = 3'd4;
    end
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_result", 32'(out_result), 32'(sb_q[0].res));
      @(negedge clk);
    end
    out_ready = 1'b1;
    e = sb_q.pop_front();
    check_eq($sformatf("result_op%0d", op), 32'(out_result), 32'(e.res));
    check_eq($sformatf("cout_op%0d", op), 32'(out_cout), 32'(e.cout));
    check_eq($sformatf("zero_op%0d", op), 32'(out_zero), 32'(e.zero));
    check_eq($sformatf("err_op%0d", op), 32'(out_err), 32'(e.err));
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    check_eq($sformatf("ovf_op%0d", op), 32'(out_ovf), 32'(e.ovf));
`endif
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("valid_drops", 32'(out_valid), 32'd0);
    check_eq("ready_after_done", 32'(in_ready), 32'd1);
  endtask

  task automatic reset_mid_run();
    in_valid = 1'b1;
    in_a     = 16'h1234;
    in_b     = 16'h4321;
    in_op    = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_run_nib2_drive", 32'(drive_s), 32'(exp_drive(16'h1234, 16'h4321, 3'd1, 2)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mid_drive", 32'(drive_s), 32'd0);
    for (int n = 0; n < NIB + 3; n++) begin
      @(negedge clk);
      check_eq("rst_no_emit", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    in_op     = 3'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(out_result), 32'd0);
    check_eq("rst_flags", 32'({out_cout, out_zero, out_err}), 32'd0);
    check_eq("rst_drive", 32'(drive_s), 32'd0);

    // Reset wins over a handshake on the same edge
    in_valid = 1'b1;
    in_op    = 3'd1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_vs_accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_eq("rst_vs_accept_drive", 32'(drive_s), 32'd0);

    run_op(16'hFFFF, 16'h0001, 3'd1, 0, 1'b0);
    run_op(16'h1234, 16'h1235, 3'd2, 0, 1'b0);
    run_op(16'h1235, 16'h1234, 3'd2, 0, 1'b0);
    run_op(16'h5555, 16'h8001, 3'd3, 0, 1'b0);
    run_op(16'h5555, 16'h0007, 3'd3, 0, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 3'd0, 0, 1'b0);
    run_op(16'h1111, 16'hBEEF, 3'd5, 0, 1'b0);
    run_op(16'hCAFE, 16'h2222, 3'd4, 1, 1'b0);
    run_op(16'h1111, 16'h2222, 3'd1, 5, 1'b1);
    run_op(16'h0F0F, 16'h0101, 3'd2, 0, 1'b0);
    run_op(16'hABCD, 16'h1234, 3'd7, 0, 1'b0);
    run_op(16'hABCD, 16'h1234, 3'd6, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 3'd1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 3'd2, 0, 1'b0);
    run_op(16'h0001, 16'h0001, 3'd1, 0, 1'b0);
    reset_mid_run();
    for (int r = 0; r < 10; r++) begin
      run_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
    end

    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
